// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a sign fix-up cycle.
//
// state  | meaning
// S_IDLE | waiting for start; mthi/mtlo writes accepted
// S_CALC | WIDTH iteration cycles on operand magnitudes
// S_FIX  | apply signs / divide-by-zero result, write HI/LO
module muldiv_unit #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             rd_hilo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 op_signed;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       sub_res;
  logic                 sub_ok;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_neg;

  assign op_signed = ~md_op[0];
  assign mag1      = (op_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
  assign mag2      = (op_signed && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
  assign mul_next = {add_sum, prod_q[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend bits shift out of the low half as quotient bits enter.
  assign shifted  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign sub_ok   = shifted >= {1'b0, opnd_q};
  assign sub_res  = shifted - {1'b0, opnd_q};
  assign div_next = sub_ok ? {sub_res[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1}
                           : {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

  assign prod_neg = ~prod_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = md_op[1];
          neg_res_d = op_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
          neg_rem_d = op_signed & in1[WIDTH-1];
          cnt_d     = '0;
          busy_d    = 1'b1;
          opnd_d    = md_op[1] ? mag2 : mag1;
          prod_d    = md_op[1] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
          if (md_op[1] && (in2 == '0)) begin
            div0_d  = 1'b1;
            prod_d  = {{WIDTH{1'b0}}, in1};
            state_d = S_FIX;
          end else begin
            div0_d  = 1'b0;
            state_d = S_CALC;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_CALC: begin
        prod_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div0_q) begin
          hi_d = prod_q[WIDTH-1:0];
          lo_d = DIV0_LO;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? prod_neg[WIDTH-1:0] : prod_q[WIDTH-1:0];
          hi_d = neg_rem_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod_q;
        end
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (start | mthi | mtlo | rd_hilo);

endmodule
